fsm_conv_ctrl: RTL and testbench
================================

Name: fsm_conv_ctrl

Overview:
- Conv-side training-phase controller; the counterpart of the FC-side phase FSM.
- Runs the forward convolution pass (FP_C), then issues the one-cycle FP_C_complete pulse that starts the FC-side sequence.
- Waits for BP_FC_complete from the FC side, then runs backward conv (BP_C) and conv weight-gradient (WG_C), and returns to IDLE.
- Drives the conv datapath mux selects and input enable.

Parameters:
- FP_LEN, 10: cycles spent in FP_C; legal range 1..2^CNT_W.
- BP_LEN, 10: cycles spent in BP_C; legal range 1..2^CNT_W.
- WG_LEN, 10: cycles spent in WG_C; legal range 1..2^CNT_W.
- CNT_W, 4: phase counter width.
- TIMEOUT, 255: maximum WAIT_FC cycles before abort; legal range 1..2^TO_W-1.
- TO_W, 8: wait counter width.

Ports:
- clk  in  1  clock, rising edge
- fsm_rst  in  1  synchronous reset, active-high
- start  in  1  request one training iteration; sampled only in IDLE
- stride  in  1  stride mode; captured at accepted start
- BP_FC_complete  in  1  FC side finished backward pass; level or pulse
- FP_C_complete  out  1  one-cycle pulse: forward conv done
- select0  out  1  datapath select
- select1  out  1  datapath select
- in_en  out  1  conv input/compute enable
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse: WG_C finished
- err  out  1  sticky timeout flag
- curr_state  out  3  current state encoding

Behaviour:
- Interface: one clock, clk; reset fsm_rst is synchronous and active-high.
- Reset:
  - While fsm_rst is high at a clk edge: state=IDLE, all counters=0, stride_q=0, bp_pending=0.
  - All outputs 0 on the following cycle, err included.
  - Reset mid-operation aborts immediately; no completion pulses are emitted.
- State encoding: IDLE=0, FP_C=1, WAIT_FC=2, BP_C=3, WG_C=4. Values 5..7 are illegal and go to IDLE on the next edge with all outputs 0.
- All state, counters and flags are registered. Outputs are Moore, decoded from registered state, except where noted.
- IDLE:
  - start=1 at edge t moves to FP_C at t+1, with stride_q<=stride, err<=0, bp_pending<=0.
  - start is ignored in every other state.
- Phase counter:
  - Cleared on entry to each timed state (FP_C, BP_C, WG_C).
  - Increments every cycle while in that state.
  - Leaves the state on the cycle where count==LEN-1, so each phase lasts exactly LEN cycles.
- FP_C:
  - in_en=1.
  - select0=select1=stride_q.
  - After FP_LEN cycles, go to WAIT_FC.
- FP_C_complete: a registered pulse, high exactly on the first WAIT_FC cycle, i.e. start edge + FP_LEN + 1.
- bp_pending:
  - Set whenever BP_FC_complete=1 in FP_C or WAIT_FC, so an early pulse is never lost.
  - Cleared on entry to BP_C.
- WAIT_FC:
  - in_en=0; selects=0.
  - If BP_FC_complete=1 or bp_pending=1, go to BP_C next cycle (minimum one WAIT_FC cycle).
  - Otherwise wait_cnt increments. When wait_cnt==TIMEOUT-1 with no event, go to IDLE with err<=1; FP_C_complete is not re-pulsed and done is not pulsed.
  - wait_cnt is cleared on WAIT_FC entry.
  - If BP_FC_complete arrives on the same cycle as the timeout, the event wins: go to BP_C, no err.
- BP_C: in_en=1; selects=stride_q; lasts BP_LEN cycles, then WG_C.
- WG_C: in_en=1; selects=stride_q; lasts WG_LEN cycles, then IDLE.
- done: a registered pulse, high on the first IDLE cycle after WG_C.
- busy: high in FP_C, WAIT_FC, BP_C and WG_C.
- stride changes mid-iteration have no effect; only stride_q is used.
- BP_FC_complete in IDLE, BP_C or WG_C is ignored.
- start held high continuously re-triggers one cycle after done; IDLE is occupied for exactly one cycle.
- Full iteration length with an immediate BP_FC_complete: FP_LEN + 1 + BP_LEN + WG_LEN cycles of busy.

Test Plan:
- Reset, then a single-cycle start with stride=0 and BP_FC_complete asserted on the 1st WAIT_FC cycle:
  - in_en high for 10 cycles, then 1 low cycle, then 20 high cycles.
  - FP_C_complete pulses at start+11.
  - done pulses at start+32.
  - selects stay 0 throughout.
- stride=1 at start, toggled to 0 mid-FP_C -> select0=select1=1 in every FP_C, BP_C and WG_C cycle; 0 in WAIT_FC and IDLE.
- BP_FC_complete one-cycle pulse during FP_C (cycle 5) -> bp_pending is latched; WAIT_FC lasts exactly 1 cycle, then BP_C.
- BP_FC_complete never asserted, TIMEOUT=255 -> IDLE after 255 WAIT_FC cycles; err=1, no done; err clears at the next accepted start.
- fsm_rst asserted on BP_C cycle 4 -> next cycle: IDLE, all outputs 0, no done pulse; a subsequent start runs a normal iteration.
- start pulsed during BP_C, then start held high from done onward -> the mid-run start is ignored; a new FP_C begins the cycle after the done cycle.

Source files
------------

// File: rtl/fsm_conv_ctrl_if.sv
// Handshake/status bundle between the conv-side phase controller and its
// surroundings (FC-side FSM, conv datapath, host sequencer).
interface fsm_conv_ctrl_if;
   logic       start;
   logic       stride;
   logic       BP_FC_complete;
   logic       FP_C_complete;
   logic       select0;
   logic       select1;
   logic       in_en;
   logic       busy;
   logic       done;
   logic       err;
   logic [2:0] curr_state;

   // Sequencer / FC side: drives requests, observes status
   modport master (
      output start, stride, BP_FC_complete,
      input  FP_C_complete, select0, select1, in_en, busy, done, err, curr_state
   );

   // Controller side
   modport slave (
      input  start, stride, BP_FC_complete,
      output FP_C_complete, select0, select1, in_en, busy, done, err, curr_state
   );
endinterface

// File: rtl/fsm_conv_ctrl.sv
// Conv-side training-phase controller: FP_C -> WAIT_FC -> BP_C -> WG_C -> IDLE.
// Forward conv completion is handed to the FC side as a one-cycle pulse; the
// backward pass starts once the FC side reports BP_FC_complete (an early
// report during FP_C is latched so it is never lost).
module fsm_conv_ctrl #(
   parameter int FP_LEN  = 10,
   parameter int BP_LEN  = 10,
   parameter int WG_LEN  = 10,
   parameter int CNT_W   = 4,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic             clk,
   input  logic             fsm_rst,
   fsm_conv_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FP_C    = 3'd1,
      WAIT_FC = 3'd2,
      BP_C    = 3'd3,
      WG_C    = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] FP_LAST = CNT_W'(FP_LEN - 1);
   localparam logic [CNT_W-1:0] BP_LAST = CNT_W'(BP_LEN - 1);
   localparam logic [CNT_W-1:0] WG_LAST = CNT_W'(WG_LEN - 1);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TO_W-1:0]   wait_q, wait_d;
   logic              stride_q, stride_d;
   logic              bp_pend_q, bp_pend_d;
   logic              fpc_q, fpc_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              in_en, sel, busy;

   // State, counters and flags; reset aborts any phase without pulses
   always_ff @(posedge clk) begin
      if (fsm_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         wait_q    <= '0;
         stride_q  <= 1'b0;
         bp_pend_q <= 1'b0;
         fpc_q     <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wait_q    <= wait_d;
         stride_q  <= stride_d;
         bp_pend_q <= bp_pend_d;
         fpc_q     <= fpc_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Next-state logic; the phase counter restarts at 0 on every phase change
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      wait_d    = wait_q;
      stride_d  = stride_q;
      bp_pend_d = bp_pend_q;
      fpc_d     = 1'b0;
      done_d    = 1'b0;
      err_d     = err_q;
      unique case (state_q)
         IDLE: begin
            cnt_d  = '0;
            wait_d = '0;
            if (bus.start) begin
               state_d   = FP_C;
               stride_d  = bus.stride;
               err_d     = 1'b0;
               bp_pend_d = 1'b0;
            end
         end
         FP_C: begin
            if (bus.BP_FC_complete) bp_pend_d = 1'b1;
            if (cnt_q == FP_LAST) begin
               state_d = WAIT_FC;
               cnt_d   = '0;
               wait_d  = '0;
               fpc_d   = 1'b1;
            end
         end
         WAIT_FC: begin
            cnt_d = '0;
            // An event on the timeout cycle still wins over the abort
            if (bus.BP_FC_complete || bp_pend_q) begin
               state_d   = BP_C;
               bp_pend_d = 1'b0;
            end else if (wait_q == TO_LAST) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_q + TO_W'(1);
            end
         end
         BP_C: begin
            if (cnt_q == BP_LAST) begin
               state_d = WG_C;
               cnt_d   = '0;
            end
         end
         WG_C: begin
            if (cnt_q == WG_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end
         end
         default: begin
            // Unreachable encodings recover to a fully quiet IDLE
            state_d   = IDLE;
            cnt_d     = '0;
            wait_d    = '0;
            stride_d  = 1'b0;
            bp_pend_d = 1'b0;
            err_d     = 1'b0;
         end
      endcase
   end

   // Moore output decode from the registered state
   always_comb begin
      in_en = 1'b0;
      sel   = 1'b0;
      busy  = 1'b0;
      case (state_q)
         FP_C, BP_C, WG_C: begin
            in_en = 1'b1;
            sel   = stride_q;
            busy  = 1'b1;
         end
         WAIT_FC: busy = 1'b1;
         default: ;
      endcase
   end

   assign bus.in_en         = in_en;
   assign bus.select0       = sel;
   assign bus.select1       = sel;
   assign bus.busy          = busy;
   assign bus.FP_C_complete = fpc_q;
   assign bus.done          = done_q;
   assign bus.err           = err_q;
   assign bus.curr_state    = state_q;

endmodule

// File: tb/tb_fsm_conv_ctrl.sv
// Scoreboard bench for fsm_conv_ctrl: the stimulus process drives each cycle
// and queues the hand-derived expected outputs for that cycle; a monitor pops
// and compares on every falling edge.
module tb_fsm_conv_ctrl;
   localparam int FP_LEN = 10;
   localparam int BP_LEN = 10;
   localparam int WG_LEN = 10;

   typedef struct packed {
      logic [2:0] st;
      logic       in_en;
      logic       s0;
      logic       s1;
      logic       busy;
      logic       fpc;
      logic       done;
      logic       err;
   } exp_t;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc_no = 0;
   exp_t sb[$];

   fsm_conv_ctrl_if bus();

   fsm_conv_ctrl #(
      .FP_LEN(FP_LEN), .BP_LEN(BP_LEN), .WG_LEN(WG_LEN),
      .CNT_W(4), .TIMEOUT(255), .TO_W(8)
   ) dut (
      .clk    (clk),
      .fsm_rst(rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one expected vector per checked cycle
   always @(negedge clk) begin
      exp_t e, g;
      cyc_no++;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         g.st    = bus.curr_state;
         g.in_en = bus.in_en;
         g.s0    = bus.select0;
         g.s1    = bus.select1;
         g.busy  = bus.busy;
         g.fpc   = bus.FP_C_complete;
         g.done  = bus.done;
         g.err   = bus.err;
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL outputs cycle %0d: got st=%0d en=%b s0=%b s1=%b busy=%b fpc=%b done=%b err=%b, want st=%0d en=%b s0=%b s1=%b busy=%b fpc=%b done=%b err=%b",
                     cyc_no, g.st, g.in_en, g.s0, g.s1, g.busy, g.fpc, g.done, g.err,
                     e.st, e.in_en, e.s0, e.s1, e.busy, e.fpc, e.done, e.err);
         end
      end
   end

   // Drive one cycle and queue what the outputs must be during that cycle
   task automatic cyc(input logic r, input logic s, input logic sd, input logic bp,
                      input logic [2:0] est, input logic esel, input logic efpc,
                      input logic edone, input logic eerr);
      exp_t e;
      rst                = r;
      bus.start          = s;
      bus.stride         = sd;
      bus.BP_FC_complete = bp;
      e.st    = est;
      e.in_en = (est == 3'd1) || (est == 3'd3) || (est == 3'd4);
      e.s0    = e.in_en & esel;
      e.s1    = e.in_en & esel;
      e.busy  = e.in_en || (est == 3'd2);
      e.fpc   = efpc;
      e.done  = edone;
      e.err   = eerr;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // One training iteration:
   //  flip      FP cycle from which the stride input is inverted (0 = never)
   //  early     FP cycle carrying a one-cycle BP_FC_complete (0 = none)
   //  wn        number of WAIT_FC cycles expected
   //  bp_last   drive BP_FC_complete on the last WAIT_FC cycle
   //  to_bp     WAIT_FC ends in BP_C (else timeout back to IDLE with err)
   //  skip_idle start was already accepted on the previous done cycle
   //  rst_bp    BP cycle on which fsm_rst is asserted (0 = none)
   //  mid_start BP cycle with a stray start pulse (0 = none)
   //  end_start hold start high on the done cycle
   task automatic run_iter(input logic sd, input int flip, input int early, input int wn,
                           input bit bp_last, input bit to_bp, input bit skip_idle,
                           input logic err_before, input int rst_bp, input int mid_start,
                           input bit end_start);
      if (!skip_idle) cyc(1'b0, 1'b1, sd, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, err_before);
      for (int i = 1; i <= FP_LEN; i++)
         cyc(1'b0, 1'b0, (flip != 0 && i >= flip) ? ~sd : sd, (early == i),
             3'd1, sd, 1'b0, 1'b0, 1'b0);
      for (int w = 1; w <= wn; w++)
         cyc(1'b0, 1'b0, 1'b0, bp_last && (w == wn), 3'd2, 1'b0, (w == 1), 1'b0, 1'b0);
      if (!to_bp) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
         return;
      end
      for (int i = 1; i <= BP_LEN; i++) begin
         if (i == rst_bp) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, sd, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            return;
         end
         cyc(1'b0, (i == mid_start), 1'b0, 1'b1, 3'd3, sd, 1'b0, 1'b0, 1'b0);
      end
      for (int i = 1; i <= WG_LEN; i++)
         cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd4, sd, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, end_start, sd, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.stride = 1'b0;
      bus.BP_FC_complete = 1'b0;
      @(posedge clk);
      #1;
      // reset state
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      // stride 0, FC completes on first WAIT_FC cycle
      run_iter(1'b0, 0, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      // stride 1 captured, input toggled mid-FP_C
      run_iter(1'b1, 3, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      // early BP_FC_complete in FP_C cycle 5 -> single WAIT_FC cycle
      run_iter(1'b0, 0, 5, 1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      // no FC event: timeout after 255 WAIT_FC cycles, err sticky
      run_iter(1'b0, 0, 0, 255, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      // err clears at start; event on the timeout cycle wins
      run_iter(1'b1, 0, 0, 255, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
      // reset on BP_C cycle 4, then a normal iteration
      run_iter(1'b1, 0, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 4, 0, 1'b0);
      run_iter(1'b0, 0, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      // stray start in BP_C ignored; start on done cycle re-triggers
      run_iter(1'b1, 0, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2, 1'b1);
      run_iter(1'b1, 0, 0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected vectors left unchecked, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
